// File: rtl/sr_run_ctrl_if.sv
// Host/CPU-side signal bundle for the run-control sequencer.
// master: host, debug port and CPU-side pc/breakpoint sources. slave: the sequencer.
interface sr_run_ctrl_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_arg;
    logic [PC_W-1:0]  pc;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic             cpu_en;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, pc, bp_en, bp_addr,
        input  cmd_ready, cpu_en, halted, halt_cause, instr_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, pc, bp_en, bp_addr,
        output cmd_ready, cpu_en, halted, halt_cause, instr_cnt
    );
endinterface

// File: rtl/sr_run_ctrl.sv
// Run-control sequencer for the schoolRISCV core: gates the CPU clock enable so a host can
// halt, resume, single-step or run N instructions, with a PC breakpoint and a retire counter.
module sr_run_ctrl #(
    parameter int unsigned PC_W          = 32,
    parameter int unsigned CNT_W         = 16,
    parameter bit          START_RUNNING = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    sr_run_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        StHalted = 2'd0,
        StRun    = 2'd1,
        StStep   = 2'd2,
        StRunN   = 2'd3
    } state_t;

    localparam logic [1:0] OpHalt = 2'd0;
    localparam logic [1:0] OpRun  = 2'd1;
    localparam logic [1:0] OpStep = 2'd2;
    localparam logic [1:0] OpRunN = 2'd3;

    localparam logic [1:0] CauseNone = 2'd0;
    localparam logic [1:0] CauseHost = 2'd1;
    localparam logic [1:0] CauseDone = 2'd2;
    localparam logic [1:0] CauseBp   = 2'd3;

    localparam state_t ResetState = START_RUNNING ? StRun : StHalted;

    state_t           stateQ, stateD;
    logic [CNT_W-1:0] remainingQ, remainingD;
    logic             bpSkipQ, bpSkipD;
    logic [1:0]       causeQ, causeD;
    logic [CNT_W-1:0] instrCntQ, instrCntD;

    logic bpHit;
    logic cpuEn;
    logic cmdReady;
    logic cmdFire;

    // Breakpoint match, CPU enable and command handshake; purely combinational.
    always_comb begin
        // bpSkip lets the instruction parked on the breakpoint execute once after a resume
        bpHit    = bus.bp_en && (bus.pc == bus.bp_addr) && !bpSkipQ;
        cpuEn    = (stateQ != StHalted) && !bpHit;
        // Run-type ops issued mid-run stay pending; HALT is always taken
        cmdReady = (stateQ == StHalted) || (bus.cmd_op == OpHalt);
        cmdFire  = bus.cmd_valid && cmdReady;
    end

    // Next-state: command decode when halted, stop conditions in priority order when running.
    always_comb begin
        stateD     = stateQ;
        remainingD = remainingQ;
        bpSkipD    = bpSkipQ;
        causeD     = causeQ;
        instrCntD  = instrCntQ;

        if (cpuEn) begin
            instrCntD = instrCntQ + CNT_W'(1);
            bpSkipD   = 1'b0;
        end

        if (stateQ == StHalted) begin
            if (cmdFire) begin
                unique case (bus.cmd_op)
                    OpHalt: ;
                    OpRun: begin
                        stateD  = StRun;
                        bpSkipD = 1'b1;
                        causeD  = CauseNone;
                    end
                    OpStep: begin
                        stateD  = StStep;
                        bpSkipD = 1'b1;
                        causeD  = CauseNone;
                    end
                    OpRunN: begin
                        if (bus.cmd_arg == '0) begin
                            causeD = CauseDone;
                        end else begin
                            stateD     = StRunN;
                            remainingD = bus.cmd_arg;
                            bpSkipD    = 1'b1;
                            causeD     = CauseNone;
                        end
                    end
                endcase
            end
        end else if (cmdFire && (bus.cmd_op == OpHalt)) begin
            stateD = StHalted;
            causeD = CauseHost;
        end else if (bpHit) begin
            stateD = StHalted;
            causeD = CauseBp;
        end else if (stateQ == StStep) begin
            stateD = StHalted;
            causeD = CauseDone;
        end else if (stateQ == StRunN) begin
            remainingD = remainingQ - CNT_W'(1);
            if (remainingQ == CNT_W'(1)) begin
                stateD = StHalted;
                causeD = CauseDone;
            end
        end
    end

    // State and counter registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= ResetState;
            remainingQ <= '0;
            bpSkipQ    <= 1'b0;
            causeQ     <= CauseNone;
            instrCntQ  <= '0;
        end else begin
            stateQ     <= stateD;
            remainingQ <= remainingD;
            bpSkipQ    <= bpSkipD;
            causeQ     <= causeD;
            instrCntQ  <= instrCntD;
        end
    end

    assign bus.cmd_ready  = cmdReady;
    assign bus.cpu_en     = cpuEn;
    assign bus.halted     = (stateQ == StHalted);
    assign bus.halt_cause = causeQ;
    assign bus.instr_cnt  = instrCntQ;

endmodule

// File: doc/sr_run_ctrl.md
Name: sr_run_ctrl

Overview:
Run-control sequencer for the single-cycle schoolRISCV core. It drives the CPU clock-enable so a host or debug port can halt, resume, single-step or run the core for N instructions, and can stop it on a PC breakpoint. It sits between the clock divider output and the core's enable, next to the register-file debug read port. It also provides an executed-instruction counter.

Parameters:
PC_W, 32, width of PC and breakpoint address
CNT_W, 16, width of run-count argument and instruction counter
START_RUNNING, 0, if 1 the reset state is RUN instead of HALTED

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge clk
cmd_op  in  2  0=HALT, 1=RUN, 2=STEP, 3=RUN_N
cmd_arg  in  CNT_W  instruction count for RUN_N
pc  in  PC_W  current CPU pc (address of instruction executing this cycle)
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint address
cpu_en  out  1  CPU clock enable; one instruction retires per cycle high
halted  out  1  state == HALTED
halt_cause  out  2  0=NONE, 1=HOST, 2=STEP/RUN_N done, 3=BREAKPOINT
instr_cnt  out  CNT_W  count of cycles with cpu_en=1, wraps modulo 2^CNT_W

Behaviour:
- States: HALTED, RUN, STEP, RUN_N. Registered: state, remaining[CNT_W], bp_skip, halt_cause, instr_cnt.
- Reset (async, rst_n=0): state=HALTED (RUN if START_RUNNING=1), remaining=0, bp_skip=0, halt_cause=NONE, instr_cnt=0. Outputs: cpu_en=0 (1 if START_RUNNING and no bp_hit), halted=1 (0 if START_RUNNING). Reset mid-operation aborts any run immediately.
- bp_hit = bp_en && (pc == bp_addr) && !bp_skip (combinational).
- cpu_en = (state != HALTED) && !bp_hit (combinational; no dependence on cmd_*).
- cmd_ready = (state == HALTED) || (cmd_op == HALT). Run-type ops during a run are not accepted and stay pending.
- Accepted in HALTED:
  - RUN: go to RUN.
  - STEP: go to STEP.
  - RUN_N with arg=0: stay HALTED, halt_cause=DONE.
  - RUN_N with arg=N>0: go to RUN_N, remaining=N.
  - HALT: no-op, cause unchanged.
  - Any accepted run op (RUN, STEP, RUN_N>0) sets bp_skip=1 and halt_cause=NONE.
- Timing: a command accepted at edge k gives cpu_en=1 in cycle k..k+1 (first instruction retires at edge k+1).
- bp_skip clears at the first edge where cpu_en=1, so an instruction sitting at bp_addr on resume executes once.
- In RUN/STEP/RUN_N, priority at each edge:
  1. HALT accepted: go to HALTED, cause=HOST. The instruction in the acceptance cycle still executes if cpu_en=1.
  2. bp_hit: go to HALTED, cause=BREAKPOINT; no instruction executes that cycle.
  3. STEP with cpu_en=1: go to HALTED, cause=DONE (exactly one instruction).
  4. RUN_N with cpu_en=1: remaining decrements; if remaining==1 go to HALTED, cause=DONE (exactly N instructions).
  5. RUN: stay in RUN.
- instr_cnt increments at every edge with cpu_en=1 and wraps from 2^CNT_W-1 to 0. It is cleared only by reset.
- halted is a direct decode of state.

Test Plan:
- Reset, then RUN at cycle 5, HALT at cycle 15 -> cpu_en high in cycles 5..15, instr_cnt=11, halt_cause=1, halted=1.
- STEP from HALTED, pc=0x08 -> cpu_en high exactly 1 cycle, instr_cnt+1, halt_cause=2; a second STEP while stepping is held (cmd_ready=0).
- RUN_N arg=7 -> exactly 7 cpu_en cycles, halt_cause=2; RUN_N arg=0 -> cpu_en stays 0, halt_cause=2 next edge.
- bp_en=1, bp_addr=0x10, RUN from pc=0 with pc advancing by 4 -> halt with pc=0x10, cpu_en=0 that cycle, halt_cause=3, instr_cnt=4. RUN again -> 0x10 executes, pc reaches 0x14.
- HALT issued in the same cycle as bp_hit -> halt_cause=1, no instruction retired that cycle; rst_n pulsed low mid-RUN_N -> cpu_en=0, instr_cnt=0 immediately.
- instr_cnt wrap with CNT_W=4: RUN 17 cycles -> instr_cnt=1.
